sys_bus_ctrl: RTL and testbench

//   Parametrised bus fabric for the 65C02 SoC; replaces the hard-wired decode, read-data mux and IRQ OR in the top level.

---
 rtl/sys_bus_pkg.sv | 24 ++
 rtl/sys_bus_ctrl_irq.sv | 74 +++++++
 rtl/sys_bus_ctrl.sv | 139 +++++++++++++
 tb/tb_sys_bus_ctrl.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sys_bus_pkg.sv
// sys_bus_pkg: shared constants and types for the 65C02 SoC bus fabric.
//   - CSR register offsets of the interrupt controller window
//   - wait-state FSM encoding
//   - default SoC memory map (slot0 in the LSBs of every packed vector)
package sys_bus_pkg;

  localparam logic [1:0] CSR_STATUS  = 2'd0;
  localparam logic [1:0] CSR_ENABLE  = 2'd1;
  localparam logic [1:0] CSR_PENDING = 2'd2;
  localparam logic [1:0] CSR_ACTIVE  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } wait_state_e;

  localparam logic [63:0] DEF_SLOT_BASE = {16'h8000, 16'h6000, 16'h5000, 16'h0000};
  localparam logic [63:0] DEF_SLOT_MASK = {16'h8000, 16'hFFF0, 16'hFFF0, 16'hC000};
  localparam logic [15:0] DEF_SLOT_WAIT = {4'd0, 4'd0, 4'd0, 4'd0};
  localparam logic [15:0] DEF_CSR_BASE  = 16'h5F00;
  localparam logic [7:0]  DEF_OPEN_BUS  = 8'hFF;

endpackage

// File: rtl/sys_bus_ctrl_irq.sv
// irq_ctrl: interrupt controller behind the 4-byte CSR window.
//   clk, reset   : clock, synchronous active-high reset
//   irq_n        : active-low requests (already in the clk domain)
//   csr_we       : CSR write strobe (already qualified by cpu_rdy)
//   csr_off      : register offset within the window
//   csr_wdata    : write data
//   csr_rdata    : read data, bits >= NUM_IRQ read as 0
//   cpu_irq      : registered |(PENDING & ENABLE)
module irq_ctrl
  import sys_bus_pkg::*;
#(
  parameter int                 NUM_IRQ  = 2,
  parameter logic [NUM_IRQ-1:0] IRQ_EDGE = '0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_IRQ-1:0] irq_n,
  input  logic               csr_we,
  input  logic [1:0]         csr_off,
  input  logic [7:0]         csr_wdata,
  output logic [7:0]         csr_rdata,
  output logic               cpu_irq
);

  logic [NUM_IRQ-1:0] irq_q;
  logic [NUM_IRQ-1:0] irq_q_d;
  logic [NUM_IRQ-1:0] enable;
  logic [NUM_IRQ-1:0] pend_edge;
  logic [NUM_IRQ-1:0] pending;
  logic [NUM_IRQ-1:0] rise;
  logic [NUM_IRQ-1:0] w1c;
  logic [NUM_IRQ-1:0] rd;

  // Upper write-data bits have no register behind them.
  logic unused_wdata;
  assign unused_wdata = &{1'b0, csr_wdata};

  assign rise = irq_q & ~irq_q_d;
  assign w1c  = (csr_we && csr_off == CSR_PENDING) ? csr_wdata[NUM_IRQ-1:0] : '0;

  // Level sources follow the sampled line directly; only edge sources
  // have a sticky latch, so W1C simply has nothing to clear on level bits.
  assign pending = (pend_edge & IRQ_EDGE) | (irq_q & ~IRQ_EDGE);

  always_ff @(posedge clk) begin
    if (reset) begin
      irq_q     <= '0;
      irq_q_d   <= '0;
      enable    <= '0;
      pend_edge <= '0;
      cpu_irq   <= 1'b0;
    end else begin
      irq_q     <= ~irq_n;
      irq_q_d   <= irq_q;
      // Set is ORed in after the clear, so a coincident edge survives.
      pend_edge <= ((pend_edge & ~w1c) | rise) & IRQ_EDGE;
      if (csr_we && csr_off == CSR_ENABLE) enable <= csr_wdata[NUM_IRQ-1:0];
      cpu_irq   <= |(pending & enable);
    end
  end

  always_comb begin
    rd        = '0;
    csr_rdata = '0;
    case (csr_off)
      CSR_STATUS:  rd = irq_q;
      CSR_ENABLE:  rd = enable;
      CSR_PENDING: rd = pending;
      default:     rd = pending & enable;
    endcase
    csr_rdata[NUM_IRQ-1:0] = rd;
  end

endmodule

// File: rtl/sys_bus_ctrl.sv
// sys_bus_ctrl: bus fabric for the 65C02 SoC.
//   clk, reset     : CPU clock, synchronous active-high reset
//   cpu_ad/we/do   : CPU address, write enable, write data
//   cpu_di         : read data (slot, IRQ CSR or OPEN_BUS on a miss)
//   cpu_rdy        : 0 stalls the CPU during slot wait states
//   cpu_irq        : interrupt to the CPU
//   bus_addr       : registered address presented to the slots
//   slot_cs        : one-hot slot select decoded from bus_addr
//   slot_we        : write strobe, one per CPU write
//   slot_do        : packed slot read data, slot0 in LSBs
//   irq_n          : active-low interrupt requests
//   dbg_wait_state : wait FSM state (wait_state_e encoding)
//
// Handshake: cpu_rdy is the ready of the access held in bus_addr. While it
// is 0 the CPU holds its bus and bus_addr is frozen; the access completes
// (and a write strobes) in the single cycle where cpu_rdy is 1.
module sys_bus_ctrl
  import sys_bus_pkg::*;
#(
  parameter int                       NUM_SLOTS = 4,
  parameter logic [16*NUM_SLOTS-1:0]  SLOT_BASE = DEF_SLOT_BASE,
  parameter logic [16*NUM_SLOTS-1:0]  SLOT_MASK = DEF_SLOT_MASK,
  parameter logic [4*NUM_SLOTS-1:0]   SLOT_WAIT = DEF_SLOT_WAIT,
  parameter int                       NUM_IRQ   = 2,
  parameter logic [NUM_IRQ-1:0]       IRQ_EDGE  = 2'b00,
  parameter logic [15:0]              CSR_BASE  = DEF_CSR_BASE,
  parameter logic [7:0]               OPEN_BUS  = DEF_OPEN_BUS
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [15:0]            cpu_ad,
  input  logic                   cpu_we,
  input  logic [7:0]             cpu_do,
  output logic [7:0]             cpu_di,
  output logic                   cpu_rdy,
  output logic                   cpu_irq,
  output logic [15:0]            bus_addr,
  output logic [NUM_SLOTS-1:0]   slot_cs,
  output logic                   slot_we,
  input  logic [8*NUM_SLOTS-1:0] slot_do,
  input  logic [NUM_IRQ-1:0]     irq_n,
  output logic [1:0]             dbg_wait_state
);

  wait_state_e state, state_nxt;
  logic [3:0]  cnt, cnt_nxt;
  logic        csr_hit;
  logic        slot_hit;
  logic [2:0]  slot_sel;
  logic [3:0]  sel_wait;
  logic [7:0]  sel_data;
  logic [7:0]  csr_rdata;
  logic        csr_we;

  assign dbg_wait_state = state;

  always_ff @(posedge clk) begin
    if (reset)        bus_addr <= 16'h0000;
    else if (cpu_rdy) bus_addr <= cpu_ad;
  end

  assign csr_hit = (bus_addr[15:2] == CSR_BASE[15:2]);

  // Scan from the top down so the lowest matching index is the one kept.
  always_comb begin
    slot_hit = 1'b0;
    slot_sel = '0;
    sel_wait = '0;
    sel_data = '0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if ((bus_addr & SLOT_MASK[16*i +: 16]) == SLOT_BASE[16*i +: 16]) begin
        slot_hit = 1'b1;
        slot_sel = 3'(i);
        sel_wait = SLOT_WAIT[4*i +: 4];
        sel_data = slot_do[8*i +: 8];
      end
    end
    if (csr_hit) slot_hit = 1'b0;
    slot_cs = slot_hit ? (NUM_SLOTS'(1) << slot_sel) : '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // The IDLE cycle that sees the hit is itself the first stall cycle, so
  // the counter is loaded with N-1 and WAIT covers the remaining N-1.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    cpu_rdy   = 1'b1;
    case (state)
      ST_IDLE: begin
        if (slot_hit && sel_wait != 4'd0) begin
          cpu_rdy   = 1'b0;
          cnt_nxt   = sel_wait - 4'd1;
          state_nxt = (sel_wait == 4'd1) ? ST_DONE : ST_WAIT;
        end
      end
      ST_WAIT: begin
        cpu_rdy = 1'b0;
        if (cnt <= 4'd1) state_nxt = ST_DONE;
        else             cnt_nxt   = cnt - 4'd1;
      end
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign slot_we = cpu_we & cpu_rdy & (slot_hit | csr_hit);
  assign csr_we  = cpu_we & cpu_rdy & csr_hit;

  always_comb begin
    if (csr_hit)       cpu_di = csr_rdata;
    else if (slot_hit) cpu_di = sel_data;
    else               cpu_di = OPEN_BUS;
  end

  irq_ctrl #(
    .NUM_IRQ  (NUM_IRQ),
    .IRQ_EDGE (IRQ_EDGE)
  ) u_irq (
    .clk       (clk),
    .reset     (reset),
    .irq_n     (irq_n),
    .csr_we    (csr_we),
    .csr_off   (bus_addr[1:0]),
    .csr_wdata (cpu_do),
    .csr_rdata (csr_rdata),
    .cpu_irq   (cpu_irq)
  );

endmodule

// File: tb/tb_sys_bus_ctrl.sv
module tb_sys_bus_ctrl;

  logic        clk;
  logic        reset;
  logic [15:0] cpu_ad;
  logic        cpu_we;
  logic [7:0]  cpu_do;
  logic [7:0]  cpu_di;
  logic        cpu_rdy;
  logic        cpu_irq;
  logic [15:0] bus_addr;
  logic [3:0]  slot_cs;
  logic        slot_we;
  logic [31:0] slot_do;
  logic [1:0]  irq_n;
  logic [1:0]  dbg_wait_state;

  int checks = 0;
  int errors = 0;

  // slot3=A9, slot2=62, slot1=51, slot0=00
  assign slot_do = 32'hA962_5100;

  sys_bus_ctrl #(
    .SLOT_WAIT (16'h0300),
    .IRQ_EDGE  (2'b10)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .cpu_ad         (cpu_ad),
    .cpu_we         (cpu_we),
    .cpu_do         (cpu_do),
    .cpu_di         (cpu_di),
    .cpu_rdy        (cpu_rdy),
    .cpu_irq        (cpu_irq),
    .bus_addr       (bus_addr),
    .slot_cs        (slot_cs),
    .slot_we        (slot_we),
    .slot_do        (slot_do),
    .irq_n          (irq_n),
    .dbg_wait_state (dbg_wait_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    int stalls;
    int we_cnt;
    int bad_we;
    logic saw_rdy;

    reset  = 1'b1;
    cpu_ad = 16'h0000;
    cpu_we = 1'b0;
    cpu_do = 8'h00;
    irq_n  = 2'b11;
    tick();
    tick();
    chk("rst_bus_addr", bus_addr, 16'h0000);
    chk("rst_rdy", {15'd0, cpu_rdy}, 16'd1);
    chk("rst_irq", {15'd0, cpu_irq}, 16'd0);
    chk("rst_state", {14'd0, dbg_wait_state}, 16'd0);
    reset = 1'b0;

    // zero-wait read from slot3
    cpu_ad = 16'h8123;
    tick();
    chk("s3_bus_addr", bus_addr, 16'h8123);
    chk("s3_cs", {12'd0, slot_cs}, 16'h0008);
    chk("s3_di", {8'd0, cpu_di}, 16'h00A9);
    chk("s3_rdy", {15'd0, cpu_rdy}, 16'd1);
    tick();
    chk("s3_rdy2", {15'd0, cpu_rdy}, 16'd1);

    // read from slot2 with 3 wait states; cpu_ad moves to show bus_addr holds
    cpu_ad = 16'h6004;
    tick();
    cpu_ad = 16'h0000;
    #1;
    chk("s2_cs", {12'd0, slot_cs}, 16'h0004);
    chk("s2_di", {8'd0, cpu_di}, 16'h0062);
    stalls  = 0;
    saw_rdy = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (cpu_rdy) begin
        saw_rdy = 1'b1;
        break;
      end
      stalls++;
      chk("s2_hold_addr", bus_addr, 16'h6004);
      chk("s2_no_we", {15'd0, slot_we}, 16'd0);
      tick();
    end
    chk("s2_rdy_returned", {15'd0, saw_rdy}, 16'd1);
    chk("s2_stall_cycles", 16'(stalls), 16'd3);
    chk("s2_done_addr", bus_addr, 16'h6004);
    tick();
    chk("s2_back_idle", {14'd0, dbg_wait_state}, 16'd0);

    // write to slot2 with 3 wait states: one strobe, when cpu_rdy is 1
    cpu_ad = 16'h6004;
    tick();
    cpu_we = 1'b1;
    cpu_do = 8'h55;
    #1;
    we_cnt  = 0;
    bad_we  = 0;
    saw_rdy = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (slot_we) we_cnt++;
      if (slot_we && !cpu_rdy) bad_we++;
      if (cpu_rdy) begin
        saw_rdy = 1'b1;
        break;
      end
      tick();
    end
    cpu_we = 1'b0;
    chk("wr_rdy_returned", {15'd0, saw_rdy}, 16'd1);
    chk("wr_strobe_count", 16'(we_cnt), 16'd1);
    chk("wr_strobe_stalled", 16'(bad_we), 16'd0);

    // decode miss
    cpu_ad = 16'h7000;
    tick();
    chk("miss_cs", {12'd0, slot_cs}, 16'h0000);
    chk("miss_di", {8'd0, cpu_di}, 16'h00FF);
    chk("miss_rdy", {15'd0, cpu_rdy}, 16'd1);
    cpu_we = 1'b1;
    #1;
    chk("miss_we", {15'd0, slot_we}, 16'd0);
    cpu_we = 1'b0;

    // ENABLE write of FF, only bits [1:0] exist
    cpu_ad = 16'h5F01;
    tick();
    cpu_we = 1'b1;
    cpu_do = 8'hFF;
    #1;
    chk("csr_we", {15'd0, slot_we}, 16'd1);
    chk("csr_no_cs", {12'd0, slot_cs}, 16'h0000);
    tick();
    cpu_we = 1'b0;
    #1;
    chk("enable_rd", {8'd0, cpu_di}, 16'h0003);
    chk("irq_idle", {15'd0, cpu_irq}, 16'd0);

    // edge source 1: one-cycle low pulse on irq_n[1]
    cpu_ad = 16'h5F02;
    irq_n  = 2'b01;
    tick();
    irq_n  = 2'b11;
    chk("pend_before", {8'd0, cpu_di}, 16'h0000);
    tick();
    chk("pend_set", {8'd0, cpu_di}, 16'h0002);
    chk("irq_latency", {15'd0, cpu_irq}, 16'd0);
    tick();
    chk("irq_asserted", {15'd0, cpu_irq}, 16'd1);
    chk("pend_sticky", {8'd0, cpu_di}, 16'h0002);

    // W1C clear of bit 1
    cpu_we = 1'b1;
    cpu_do = 8'h02;
    tick();
    cpu_we = 1'b0;
    #1;
    chk("pend_cleared", {8'd0, cpu_di}, 16'h0000);
    tick();
    chk("irq_cleared", {15'd0, cpu_irq}, 16'd0);

    // new edge lands in the same cycle as a W1C of that bit: set wins
    irq_n = 2'b01;
    tick();
    irq_n  = 2'b11;
    cpu_we = 1'b1;
    cpu_do = 8'h02;
    tick();
    cpu_we = 1'b0;
    #1;
    chk("pend_set_wins", {8'd0, cpu_di}, 16'h0002);

    // level source 0: W1C has no effect
    irq_n = 2'b10;
    tick();
    chk("pend_level", {8'd0, cpu_di}, 16'h0003);
    cpu_we = 1'b1;
    cpu_do = 8'h01;
    tick();
    cpu_we = 1'b0;
    #1;
    chk("level_w1c_ignored", {8'd0, cpu_di}, 16'h0003);
    cpu_ad = 16'h5F03;
    tick();
    chk("active_rd", {8'd0, cpu_di}, 16'h0003);
    cpu_ad = 16'h5F00;
    tick();
    chk("status_rd", {8'd0, cpu_di}, 16'h0001);
    chk("irq_on_level", {15'd0, cpu_irq}, 16'd1);
    irq_n = 2'b11;

    // reset while the FSM is in WAIT with cnt=2
    cpu_ad = 16'h6004;
    tick();
    chk("rw_stall", {15'd0, cpu_rdy}, 16'd0);
    tick();
    chk("rw_in_wait", {14'd0, dbg_wait_state}, 16'd1);
    reset = 1'b1;
    tick();
    chk("rw_rdy", {15'd0, cpu_rdy}, 16'd1);
    chk("rw_state", {14'd0, dbg_wait_state}, 16'd0);
    chk("rw_irq", {15'd0, cpu_irq}, 16'd0);
    chk("rw_bus_addr", bus_addr, 16'h0000);
    reset  = 1'b0;
    cpu_ad = 16'h5F01;
    tick();
    chk("rw_enable", {8'd0, cpu_di}, 16'h0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
